fpu_sequencer: RTL

FPU_SEQUENCER -- requirements
Module: fpu_sequencer

---
 rtl/fpu_pkg.sv | 24 ++
 rtl/fpu_req_fifo.sv | 54 +++++
 rtl/fpu_sequencer.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fpu_pkg : shared op encoding, sequencer states and operand widths.    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package fpu_pkg;
    localparam int FP_W  = 16;
    localparam int OP_W  = 2;
    localparam int REQ_W = OP_W + 2 * FP_W;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } fpu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;
endpackage
`default_nettype wire

// File: rtl/fpu_req_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fpu_req_fifo : circular request queue, DEPTH entries of WIDTH bits.   |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module fpu_req_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 34
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             w_push;
    logic             w_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign w_push  = push_i && !full_o;
    assign w_pop   = pop_i && !empty_o;

    // DEPTH is a power of two, so pointer overflow is the modulo wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(w_push) - CNT_W'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) mem_q[wr_ptr_q] <= data_i;
    end
endmodule
`default_nettype wire

// File: rtl/fpu_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fpu_sequencer : queues FPU requests, issues them one at a time and    |
// | holds each result until the consumer accepts it. Rev 1.0              |
// +----------------------------------------------------------------------+
module fpu_sequencer
    import fpu_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int LATENCY = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [FP_W-1:0] in_opA,
    input  logic [FP_W-1:0] in_opB,
    input  logic [1:0]      in_op,
    output logic [FP_W-1:0] fpu_opA,
    output logic [FP_W-1:0] fpu_opB,
    output logic [1:0]      fpu_op,
    input  logic [FP_W-1:0] fpu_result,
    input  logic [3:0]      fpu_flags,
    input  logic            fpu_overflow,
    input  logic            fpu_underflow,
    input  logic            fpu_inexact,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [FP_W-1:0] out_result,
    output logic [3:0]      out_flags,
    output logic            sticky_ovf,
    output logic            sticky_unf,
    output logic            sticky_inx,
    input  logic            clr_sticky,
    output logic            busy
);
    localparam int         CNT_W = $clog2(DEPTH + 1);
    localparam logic [2:0] LAT_C = 3'(LATENCY);

    logic [REQ_W-1:0] w_req;
    logic [REQ_W-1:0] w_head;
    logic             w_full;
    logic             w_empty;
    logic [CNT_W-1:0] w_count;
    logic             w_push;
    logic             w_issue;
    logic             w_capture;

    seq_state_e       state_q;
    logic [2:0]       cnt_q;
    logic [FP_W-1:0]  opA_q;
    logic [FP_W-1:0]  opB_q;
    fpu_op_e          op_q;
    logic             out_valid_q;
    logic [FP_W-1:0]  result_q;
    logic [3:0]       flags_q;
    logic             sticky_ovf_q;
    logic             sticky_unf_q;
    logic             sticky_inx_q;

    assign w_req     = {in_op, in_opA, in_opB};
    assign w_push    = in_valid && !w_full;
    assign in_ready  = (w_count < CNT_W'(DEPTH));
    // A DONE-state handshake frees the FPU on the same edge as the next issue.
    assign w_issue   = !w_empty &&
                       ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
    assign w_capture = (state_q == ST_WAIT) && (cnt_q == 3'd0);

    fpu_req_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (w_push),
        .data_i  (w_req),
        .pop_i   (w_issue),
        .data_o  (w_head),
        .full_o  (w_full),
        .empty_o (w_empty),
        .count_o (w_count)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            cnt_q        <= 3'd0;
            opA_q        <= '0;
            opB_q        <= '0;
            op_q         <= OP_ADD;
            out_valid_q  <= 1'b0;
            result_q     <= '0;
            flags_q      <= 4'd0;
            sticky_ovf_q <= 1'b0;
            sticky_unf_q <= 1'b0;
            sticky_inx_q <= 1'b0;
        end else begin
            if (w_issue) begin
                op_q  <= fpu_op_e'(w_head[REQ_W-1 -: OP_W]);
                opA_q <= w_head[2*FP_W-1 -: FP_W];
                opB_q <= w_head[FP_W-1:0];
                cnt_q <= LAT_C;
            end
            case (state_q)
                ST_IDLE: begin
                    if (w_issue) state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (cnt_q != 3'd0) begin
                        cnt_q <= cnt_q - 3'd1;
                    end else begin
                        result_q    <= fpu_result;
                        flags_q     <= fpu_flags;
                        out_valid_q <= 1'b1;
                        state_q     <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= w_issue ? ST_WAIT : ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
            // A capture coinciding with a clear keeps the newly captured flags.
            sticky_ovf_q <= (sticky_ovf_q && !clr_sticky) || (w_capture && fpu_overflow);
            sticky_unf_q <= (sticky_unf_q && !clr_sticky) || (w_capture && fpu_underflow);
            sticky_inx_q <= (sticky_inx_q && !clr_sticky) || (w_capture && fpu_inexact);
        end
    end

    assign fpu_opA    = opA_q;
    assign fpu_opB    = opB_q;
    assign fpu_op     = op_q;
    assign out_valid  = out_valid_q;
    assign out_result = result_q;
    assign out_flags  = flags_q;
    assign sticky_ovf = sticky_ovf_q;
    assign sticky_unf = sticky_unf_q;
    assign sticky_inx = sticky_inx_q;
    assign busy       = (state_q != ST_IDLE) || !w_empty;
endmodule
`default_nettype wire
